imm_extend_pipe: RTL
====================

Name: imm_extend_pipe

Overview:
- Parametrised, registered successor to the single-stage immediate extender.
- Accepts an immediate, an extension mode and a tag over a valid/ready handshake.
- Produces the extended OUT_W-bit value one cycle later, also over valid/ready.
- Sits between the decode stage and the ALU operand mux; the tag carries the destination register index alongside the value.

Parameters:
- IN_W, 16: immediate width; legal range 8 to OUT_W-2.
- OUT_W, 32: result width.
- TAG_W, 5: sideband tag width; minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  upstream has a request
- in_ready  output  1  block can accept a request this cycle
- in_imm  input  IN_W  raw immediate
- in_mode  input  3  extension mode
- in_tag  input  TAG_W  sideband tag, passed through unchanged
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_data  output  OUT_W  extended result
- out_tag  output  TAG_W  tag of the result
- out_err  output  1  result came from an illegal mode

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid and in_ready are both 1 at a rising edge.
  - Output transfer occurs when out_valid and out_ready are both 1 at a rising edge.
- Reset, while rst is high at an edge:
  - out_valid=0, out_data=0, out_tag=0, out_err=0.
  - All internal storage is emptied.
  - in_ready is forced 0 while rst is high.
  - An in-flight result is discarded, not delivered.
  - in_ready=1 in the first cycle after rst deasserts.
- Latency: an accepted request appears on out_* at the next rising edge, i.e. 1 cycle.
- Modes, with all arithmetic done at OUT_W:
  - 0 ZERO: zero-extend in_imm to OUT_W.
  - 1 SIGN: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - 2 UPPER: in_imm << (OUT_W-IN_W); low bits are 0.
  - 3 BRANCH: sign-extend to OUT_W, then shift left 2; the top 2 bits are dropped.
  - 4 SEXT8: sign-extend in_imm[7:0]; bits above 7 of in_imm are ignored.
  - 5 ZEXT8: zero-extend in_imm[7:0].
  - 6 and 7 are illegal: out_data=0 and out_err=1. out_err=0 for all other modes.
- Ordering and integrity:
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - A stalled result is never overwritten.
  - Results leave in acceptance order; none is dropped or duplicated.
- Simultaneous events:
  - With a registered result being drained and a new input accepted in the same cycle, the new result replaces it the next cycle with out_valid held at 1.
  - In that case out_valid has no bubble between the two results.
- in_valid may fall without a transfer; the block places no obligation on upstream to hold it.

Optional Feature:
- Macro: IMM_EXTEND_SKID_EN.
- Defined:
  - A second (skid) register is added; in_ready is a registered signal equal to "skid empty".
  - An input accepted while the output stalls goes to the skid register.
  - When the main register drains, the skid entry moves into it.
  - Full throughput (1 transfer/cycle) is sustained.
  - There is no combinational path from out_ready to in_ready.
- Undefined:
  - Single register stage only; in_ready = !out_valid || out_ready, combinational.
  - Throughput is still 1/cycle when out_ready=1.
  - Ordering, reset and latency rules are identical in both builds.

Test Plan:
- Mode sweep, in_imm=16'h8001, out_ready=1, modes 0-5 in back-to-back cycles → out_data equals, in order:
  - 32'h00008001
  - 32'hFFFF8001
  - 32'h80010000
  - 32'hFFFE0004
  - 32'h00000001
  - 32'h00000001

  Each result arrives 1 cycle after its input; out_err=0 throughout.
- Illegal mode: in_mode=6, in_imm=16'hFFFF, in_tag=5'd17 → out_data=0, out_err=1, out_tag=17. The next request with mode 1 gives out_err=0.
- Backpressure, SKID build, out_ready=0 with 3 requests offered on tags 1, 2, 3:
  - Tags 1 and 2 are accepted and in_ready drops to 0; tag 3 waits.
  - Raising out_ready delivers tags 1, 2, 3 in order with no gaps.
  - out_data stays stable while stalled.
- Backpressure, non-SKID build, same stimulus:
  - Only tag 1 is accepted while stalled, and in_ready=0.
  - Once out_ready=1, tags are delivered in order 1, 2, 3.
- Streaming: 64 random requests, with random in_valid and out_ready at 50% each → the scoreboard matches the mode function and order exactly.
- Reset mid-operation: assert rst for 1 cycle while a stalled result and a skid entry are held:
  - Next cycle: out_valid=0, out_data=0, in_ready=1.
  - The held results never appear on the output.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender with valid/ready on both sides.
// The extended value, its tag and an illegal-mode flag are computed when a
// request is accepted and presented one cycle later.
// Optional feature: define IMM_EXTEND_SKID_EN to add a skid register, which
// makes in_ready a registered "skid empty" flag with no combinational path
// from out_ready.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam logic [2:0] MODE_ZERO   = 3'd0;
    localparam logic [2:0] MODE_SIGN   = 3'd1;
    localparam logic [2:0] MODE_UPPER  = 3'd2;
    localparam logic [2:0] MODE_BRANCH = 3'd3;
    localparam logic [2:0] MODE_SEXT8  = 3'd4;
    localparam logic [2:0] MODE_ZEXT8  = 3'd5;

    // Extension of one immediate; illegal modes yield zero.
    function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                    input logic [2:0]      mode);
        logic [OUT_W-1:0] sext;
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (mode)
            MODE_ZERO:   extend_imm = {{(OUT_W-IN_W){1'b0}}, imm};
            MODE_SIGN:   extend_imm = sext;
            MODE_UPPER:  extend_imm = {imm, {(OUT_W-IN_W){1'b0}}};
            MODE_BRANCH: extend_imm = {sext[OUT_W-3:0], 2'b00};
            MODE_SEXT8:  extend_imm = {{(OUT_W-8){imm[7]}}, imm[7:0]};
            MODE_ZEXT8:  extend_imm = {{(OUT_W-8){1'b0}}, imm[7:0]};
            default:     extend_imm = {OUT_W{1'b0}};
        endcase
    endfunction

    // Modes 6 and 7 have no defined extension.
    function automatic logic mode_illegal(input logic [2:0] mode);
        mode_illegal = (mode > MODE_ZEXT8);
    endfunction

    logic             in_fire_s;
    logic             out_fire_s;
    logic [OUT_W-1:0] new_data_s;
    logic             new_err_s;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;
    logic             out_err_q,   out_err_d;

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_q & out_ready;
    assign new_data_s = extend_imm(in_imm, in_mode);
    assign new_err_s  = mode_illegal(in_mode);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;

`ifdef IMM_EXTEND_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic             skid_err_q,   skid_err_d;
    logic             in_ready_q,   in_ready_d;

    // in_ready is a registered "skid empty" flag, held low during reset.
    assign in_ready = in_ready_q & ~rst;

    // Next state for main and skid registers; skid refills main when main frees up.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                // in_ready is low whenever skid is full, so no new input competes here.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_tag_d    = skid_tag_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (in_fire_s) begin
                out_valid_d = 1'b1;
                out_data_d  = new_data_s;
                out_tag_d   = in_tag;
                out_err_d   = new_err_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = new_data_s;
                skid_tag_d   = in_tag;
                skid_err_d   = new_err_s;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers for both stages, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {OUT_W{1'b0}};
            out_tag_q    <= {TAG_W{1'b0}};
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= {OUT_W{1'b0}};
            skid_tag_q   <= {TAG_W{1'b0}};
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    // Single stage: accept whenever the register is empty or being drained.
    assign in_ready = ~rst & (~out_valid_q | out_ready);

    // Next state for the single result register.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_err_d   = out_err_q;
        if (in_fire_s) begin
            out_valid_d = 1'b1;
            out_data_d  = new_data_s;
            out_tag_d   = in_tag;
            out_err_d   = new_err_s;
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Result register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_W{1'b0}};
            out_tag_q   <= {TAG_W{1'b0}};
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_err_q   <= out_err_d;
        end
    end
`endif

endmodule
